mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing one single-port data memory between the processor data port and an external requester (program loader / display reader). Each side issues one read or write per request, holds it until a one-cycle `ready` pulse, and stalls meanwhile. Sits between `processor` (`alu_result`, `write_data`, `mem_write`, `read_data`) and the data RAM.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 1, memory read latency in cycles, 1..4.

Clock, reset and the two requester ports:

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-low: sampled only on the `clk` rising edge, asserted when 0.
- `cpu_req`  in  1  processor request; held high until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  processor address.
- `cpu_wdata`  in  DATA_W  processor write data.
- `cpu_rdata`  out  DATA_W  processor read data; valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse to the processor.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_rdata`, `ext_ready`: same directions, widths and meaning for the external requester.

Memory side:

- `mem_en`  out  1  one-cycle access strobe.
- `mem_we`  out  1  write enable; only meaningful while `mem_en`=1.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid `MEM_LAT` cycles after `mem_en`.

## Operation
- The state machine has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `cpu_req` or `ext_req` is high, pick a winner, latch its `we`, `addr` and `wdata`, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - `mem_en`=1 for exactly one cycle, with the latched fields on `mem_we`, `mem_addr` and `mem_wdata`.
  - Then go to WAIT.
- WAIT:
  - Count `MEM_LAT`-1 cycles.
  - In the last WAIT cycle, register `mem_rdata` into the winner's `rdata` register, for reads only.
  - Then go to RESP.
  - When `MEM_LAT`=1, WAIT lasts one cycle and does only the capture.
- RESP:
  - Pulse the winner's `ready` for one cycle.
  - Update `last_grant` to the winner.
  - Return to IDLE.
- Arbitration is round-robin:
  - When both requesters are high in IDLE, the one that is not `last_grant` wins.
  - A single requester always wins.
- Request inputs are ignored outside IDLE.
- A requester dropping `req` mid-transaction does not abort it; `ready` still pulses.
- `rdata` registers hold their value until the next read for that requester. Writes leave `rdata` unchanged.
- Reset values:
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_ready`=0, `ext_ready`=0, `cpu_rdata`=0, `ext_rdata`=0.
  - State = IDLE, `last_grant`=EXT, so CPU wins the first tie.
- Reset mid-transaction:
  - The next edge forces IDLE and no `ready` pulse is given.
  - A write already strobed stays committed in memory.

## Timing
- Request sampled in IDLE at cycle N.
- `mem_en` high at N+1.
- Capture at N+`MEM_LAT`+1.
- `ready` high at N+`MEM_LAT`+2.
- Back in IDLE at N+`MEM_LAT`+3.
- A held or new request is sampled there. Peak throughput is one transaction per `MEM_LAT`+3 cycles.
- `cpu_ready` and `ext_ready` are never high in the same cycle.
- `mem_en` is never high on two consecutive cycles.
- All outputs are registered; there is no combinational path from `req` to `mem_*` or `ready`.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, CPU always wins a tie and `last_grant` is unused. The external requester can starve.
  - Undefined (default): round-robin as above.

## Structure
- Package `mem_arb_pkg`:
  - typedef `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP};
  - typedef `req_id_t` enum {REQ_CPU=0, REQ_EXT=1};
  - constant `MAX_MEM_LAT`=4.
- One sub-module, `mem_arb_pick`: combinational winner select from `cpu_req`, `ext_req` and `last_grant`. The `MEM_ARB_FIXED_PRIO_EN` switch is contained there.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with both `req` high.
  - Required: all outputs 0 and `mem_en` stays 0 throughout.
- **CPU read, `MEM_LAT`=1:**
  - Memory word 0x40 = 0x007E7E00.
  - `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x40 at cycle N.
  - Required: `mem_en`=1 with `mem_addr`=0x40 at N+1; `cpu_ready`=1 with `cpu_rdata`=0x007E7E00 at N+3.
- **External write:**
  - `ext_we`=1, `ext_addr`=0x10, `ext_wdata`=0xE3A0C805.
  - Required: `mem_we`=1 for one cycle; `ext_ready` at N+3; a following CPU read of 0x10 returns 0xE3A0C805.
- **Simultaneous requests:** both held high for 4 transactions.
  - Required: grant order CPU, EXT, CPU, EXT, and `ready` pulses never overlap.
  - With `MEM_ARB_FIXED_PRIO_EN` defined, the order is CPU ×4.
- **`MEM_LAT`=3:**
  - Required: `ready` at N+5, and `rdata` equals the memory contents.
- **Mid-transaction reset:** `rst`=0 in the WAIT cycle of a CPU read.
  - Required: no `cpu_ready` pulse, state returns to IDLE, and the next request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
//
// Purpose: FSM state encoding, requester identifiers and the latency ceiling
// used by mem_arbiter and mem_arb_pick.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_EXT = 1'b1
  } req_id_t;

  // Upper bound for MEM_LAT; sizes the WAIT-phase counter.
  localparam int MAX_MEM_LAT = 4;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester and memory bus bundle for the memory arbiter
//
// Purpose: groups the processor port, the external requester port and the
// single-port memory port into one interface.
// Ports (signals):
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> arbiter, cpu_rdata/cpu_ready <- arbiter
//   ext_req/ext_we/ext_addr/ext_wdata -> arbiter, ext_rdata/ext_ready <- arbiter
//   mem_en/mem_we/mem_addr/mem_wdata <- arbiter, mem_rdata -> arbiter
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding system's view (requesters plus memory)
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select for the memory arbiter
//
// Purpose: chooses which requester is granted when the arbiter is idle.
// Configuration macro: MEM_ARB_FIXED_PRIO_EN
//   defined   - CPU always wins a tie, last_grant_i is ignored
//   undefined - round-robin: on a tie the requester that is not last_grant_i wins
// Ports:
//   cpu_req_i    in  processor request
//   ext_req_i    in  external requester request
//   last_grant_i in  requester served by the previous transaction
//   valid_o      out at least one request is pending
//   grant_o      out selected requester (meaningful only while valid_o=1)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    ext_req_i,
  input  req_id_t last_grant_i,
  output logic    valid_o,
  output req_id_t grant_o
);

  assign valid_o = cpu_req_i | ext_req_i;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // History is irrelevant under fixed priority; keep the input tied off.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_o = cpu_req_i ? REQ_CPU : REQ_EXT;
  end
`else
  always_comb begin
    grant_o = REQ_CPU;
    if (cpu_req_i && ext_req_i) begin
      grant_o = (last_grant_i == REQ_CPU) ? REQ_EXT : REQ_CPU;
    end else if (ext_req_i) begin
      grant_o = REQ_EXT;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter sharing one single-port data memory
//
// Purpose: serialises processor and external requests onto one memory port.
// Each transaction runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP, with a
// one-cycle ready pulse to the winner in RESP. All outputs are registered.
// Configuration macro: MEM_ARB_FIXED_PRIO_EN (handled inside mem_arb_pick).
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..MAX_MEM_LAT)
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous reset, active low
//   bus  slave modport of mem_arb_if (cpu_*, ext_*, mem_* signals)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  localparam int              CNT_W     = $clog2(MAX_MEM_LAT);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  req_id_t           grant_q, grant_d;
  req_id_t           last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The mem_we/addr/wdata registers double as the latched request fields.
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              ext_ready_q, ext_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic              pick_valid;
  req_id_t           pick_grant;

  mem_arb_pick u_pick (
    .cpu_req_i    (bus.cpu_req),
    .ext_req_i    (bus.ext_req),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ready_d  = 1'b0;
    ext_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_grant;
          // Strobe is set here so it is registered high during ISSUE.
          mem_en_d = 1'b1;
          if (pick_grant == REQ_CPU) begin
            mem_we_d    = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
          end else begin
            mem_we_d    = bus.ext_we;
            mem_addr_d  = bus.ext_addr;
            mem_wdata_d = bus.ext_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          // Read data is valid now; ready is registered for RESP.
          if (!mem_we_q) begin
            if (grant_q == REQ_CPU) cpu_rdata_d = bus.mem_rdata;
            else                    ext_rdata_d = bus.mem_rdata;
          end
          cpu_ready_d = (grant_q == REQ_CPU);
          ext_ready_d = (grant_q == REQ_EXT);
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= REQ_CPU;
      last_grant_q <= REQ_EXT;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      ext_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ready_q  <= cpu_ready_d;
      ext_ready_q  <= ext_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.ext_ready = ext_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if)
  );
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h40) return 32'h007E7E00;
    return {~a, a, 8'h5A, a};
  endfunction

  // Memory A: latency 1. Read data is driven only in the valid cycle.
  logic [31:0] mem_a [256];
  bit          wr_a  [256];
  logic [31:0] a_p0;
  logic        a_v0 = 1'b0;
  always @(posedge clk) begin
    if (a_if.mem_en && a_if.mem_we) begin
      mem_a[a_if.mem_addr[7:0]] <= a_if.mem_wdata;
      wr_a[a_if.mem_addr[7:0]]  <= 1'b1;
    end
    a_p0 <= wr_a[a_if.mem_addr[7:0]] ? mem_a[a_if.mem_addr[7:0]] : init_word(a_if.mem_addr[7:0]);
    a_v0 <= a_if.mem_en && !a_if.mem_we;
  end
  assign a_if.mem_rdata = a_v0 ? a_p0 : 32'hDEADBEEF;

  // Memory B: latency 3.
  logic [31:0] mem_b [256];
  bit          wr_b  [256];
  logic [31:0] b_p0, b_p1, b_p2;
  logic        b_v0 = 1'b0, b_v1 = 1'b0, b_v2 = 1'b0;
  always @(posedge clk) begin
    if (b_if.mem_en && b_if.mem_we) begin
      mem_b[b_if.mem_addr[7:0]] <= b_if.mem_wdata;
      wr_b[b_if.mem_addr[7:0]]  <= 1'b1;
    end
    b_p0 <= wr_b[b_if.mem_addr[7:0]] ? mem_b[b_if.mem_addr[7:0]] : init_word(b_if.mem_addr[7:0]);
    b_v0 <= b_if.mem_en && !b_if.mem_we;
    b_p1 <= b_p0; b_v1 <= b_v0;
    b_p2 <= b_p1; b_v2 <= b_v1;
  end
  assign b_if.mem_rdata = b_v2 ? b_p2 : 32'hDEADBEEF;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_a_mem_en"},    32'(a_if.mem_en),    32'h0);
    chk({tag, "_a_mem_we"},    32'(a_if.mem_we),    32'h0);
    chk({tag, "_a_mem_addr"},  a_if.mem_addr,       32'h0);
    chk({tag, "_a_mem_wdata"}, a_if.mem_wdata,      32'h0);
    chk({tag, "_a_cpu_ready"}, 32'(a_if.cpu_ready), 32'h0);
    chk({tag, "_a_ext_ready"}, 32'(a_if.ext_ready), 32'h0);
    chk({tag, "_a_cpu_rdata"}, a_if.cpu_rdata,      32'h0);
    chk({tag, "_a_ext_rdata"}, a_if.ext_rdata,      32'h0);
  endtask

  logic prev_en;
  logic exp_cpu;
  int   idx;

  initial begin
    // Reset held two cycles with both requests high on both DUTs.
    rst = 1'b0;
    a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b0; a_if.cpu_addr = 32'h0; a_if.cpu_wdata = 32'h0;
    a_if.ext_req = 1'b1; a_if.ext_we = 1'b0; a_if.ext_addr = 32'h0; a_if.ext_wdata = 32'h0;
    b_if.cpu_req = 1'b1; b_if.cpu_we = 1'b0; b_if.cpu_addr = 32'h0; b_if.cpu_wdata = 32'h0;
    b_if.ext_req = 1'b1; b_if.ext_we = 1'b0; b_if.ext_addr = 32'h0; b_if.ext_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_reset_a("rst");
      chk("rst_b_mem_en",    32'(b_if.mem_en),    32'h0);
      chk("rst_b_cpu_ready", 32'(b_if.cpu_ready), 32'h0);
      chk("rst_b_ext_ready", 32'(b_if.ext_ready), 32'h0);
      chk("rst_b_cpu_rdata", b_if.cpu_rdata,      32'h0);
    end
    a_if.cpu_req = 1'b0; a_if.ext_req = 1'b0;
    b_if.cpu_req = 1'b0; b_if.ext_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_a_mem_en", 32'(a_if.mem_en), 32'h0);

    // CPU read 0x40, MEM_LAT=1.
    a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b0; a_if.cpu_addr = 32'h40;
    tick();
    chk("rd_n1_mem_en",   32'(a_if.mem_en), 32'h1);
    chk("rd_n1_mem_addr", a_if.mem_addr,    32'h40);
    chk("rd_n1_mem_we",   32'(a_if.mem_we), 32'h0);
    tick();
    chk("rd_n2_mem_en",    32'(a_if.mem_en),    32'h0);
    chk("rd_n2_cpu_ready", 32'(a_if.cpu_ready), 32'h0);
    tick();
    chk("rd_n3_cpu_ready", 32'(a_if.cpu_ready), 32'h1);
    chk("rd_n3_cpu_rdata", a_if.cpu_rdata,      32'h007E7E00);
    chk("rd_n3_ext_ready", 32'(a_if.ext_ready), 32'h0);
    a_if.cpu_req = 1'b0;
    tick();
    chk("rd_n4_cpu_ready", 32'(a_if.cpu_ready), 32'h0);

    // External write 0x10.
    a_if.ext_req = 1'b1; a_if.ext_we = 1'b1; a_if.ext_addr = 32'h10; a_if.ext_wdata = 32'hE3A0C805;
    tick();
    chk("wr_n1_mem_en",    32'(a_if.mem_en), 32'h1);
    chk("wr_n1_mem_we",    32'(a_if.mem_we), 32'h1);
    chk("wr_n1_mem_addr",  a_if.mem_addr,    32'h10);
    chk("wr_n1_mem_wdata", a_if.mem_wdata,   32'hE3A0C805);
    tick();
    chk("wr_n2_mem_en",    32'(a_if.mem_en),    32'h0);
    chk("wr_n2_ext_ready", 32'(a_if.ext_ready), 32'h0);
    tick();
    chk("wr_n3_ext_ready", 32'(a_if.ext_ready), 32'h1);
    chk("wr_n3_cpu_ready", 32'(a_if.cpu_ready), 32'h0);
    chk("wr_n3_ext_rdata", a_if.ext_rdata,      32'h0);
    chk("wr_n3_cpu_rdata", a_if.cpu_rdata,      32'h007E7E00);
    a_if.ext_req = 1'b0; a_if.ext_we = 1'b0;
    tick();

    // CPU reads back the written word.
    a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b0; a_if.cpu_addr = 32'h10;
    tick(); tick(); tick();
    chk("rb_cpu_ready", 32'(a_if.cpu_ready), 32'h1);
    chk("rb_cpu_rdata", a_if.cpu_rdata,      32'hE3A0C805);
    a_if.cpu_req = 1'b0;
    tick();

    // External read 0x40 leaves last_grant at EXT before the tie test.
    a_if.ext_req = 1'b1; a_if.ext_we = 1'b0; a_if.ext_addr = 32'h40;
    tick(); tick(); tick();
    chk("erd_ext_ready", 32'(a_if.ext_ready), 32'h1);
    chk("erd_ext_rdata", a_if.ext_rdata,      32'h007E7E00);
    a_if.ext_req = 1'b0;
    tick();

    // Both held high for four transactions.
    a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b0; a_if.cpu_addr = 32'h20;
    a_if.ext_req = 1'b1; a_if.ext_we = 1'b0; a_if.ext_addr = 32'h30;
    prev_en = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("tie_overlap",  32'(a_if.cpu_ready & a_if.ext_ready), 32'h0);
      chk("tie_en_b2b",   32'(a_if.mem_en & prev_en),           32'h0);
      chk("tie_mem_en",   32'(a_if.mem_en), (c % 4 == 1) ? 32'h1 : 32'h0);
      if (c % 4 == 3) begin
        idx = c / 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_cpu = 1'b1;
`else
        exp_cpu = (idx % 2 == 0);
`endif
        chk("tie_cpu_ready", 32'(a_if.cpu_ready), 32'(exp_cpu));
        chk("tie_ext_ready", 32'(a_if.ext_ready), 32'(!exp_cpu));
        if (exp_cpu) chk("tie_cpu_rdata", a_if.cpu_rdata, 32'hDF205A20);
        else         chk("tie_ext_rdata", a_if.ext_rdata, 32'hCF305A30);
      end else begin
        chk("tie_idle_ready", 32'(a_if.cpu_ready | a_if.ext_ready), 32'h0);
      end
      if (c == 15) begin
        a_if.cpu_req = 1'b0;
        a_if.ext_req = 1'b0;
      end
      prev_en = a_if.mem_en;
    end

    // Reset in the WAIT cycle of a CPU read; request stays high.
    a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b0; a_if.cpu_addr = 32'h40;
    tick();
    chk("mrst_n1_mem_en", 32'(a_if.mem_en), 32'h1);
    tick();
    rst = 1'b0;
    tick();
    chk_reset_a("mrst_n3");
    rst = 1'b1;
    tick();
    chk("mrst_n4_mem_en",    32'(a_if.mem_en),    32'h1);
    chk("mrst_n4_mem_addr",  a_if.mem_addr,       32'h40);
    chk("mrst_n4_cpu_ready", 32'(a_if.cpu_ready), 32'h0);
    tick();
    chk("mrst_n5_cpu_ready", 32'(a_if.cpu_ready), 32'h0);
    tick();
    chk("mrst_n6_cpu_ready", 32'(a_if.cpu_ready), 32'h1);
    chk("mrst_n6_cpu_rdata", a_if.cpu_rdata,      32'h007E7E00);
    a_if.cpu_req = 1'b0;
    tick();

    // MEM_LAT=3: CPU read 0x40 on the second instance.
    b_if.cpu_req = 1'b1; b_if.cpu_we = 1'b0; b_if.cpu_addr = 32'h40;
    tick();
    chk("lat3_n1_mem_en", 32'(b_if.mem_en), 32'h1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("lat3_early_ready", 32'(b_if.cpu_ready), 32'h0);
      chk("lat3_wait_mem_en", 32'(b_if.mem_en),    32'h0);
    end
    tick();
    chk("lat3_n5_cpu_ready", 32'(b_if.cpu_ready), 32'h1);
    chk("lat3_n5_cpu_rdata", b_if.cpu_rdata,      32'h007E7E00);
    chk("lat3_n5_ext_ready", 32'(b_if.ext_ready), 32'h0);
    b_if.cpu_req = 1'b0;
    tick();
    chk("lat3_n6_cpu_ready", 32'(b_if.cpu_ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
